// File: rtl/pzcorebus_pkg.sv
// Minimal slice of the corebus package: command/response encodings and the
// posted/non-posted classification used by the response filter.
package pzcorebus_pkg;

    // Bit 2 of the command encoding marks commands that expect a response.
    typedef enum logic [2:0] {
        PZCOREBUS_NULL_COMMAND       = 3'b000,
        PZCOREBUS_WRITE              = 3'b001,
        PZCOREBUS_MESSAGE            = 3'b010,
        PZCOREBUS_BROADCAST          = 3'b011,
        PZCOREBUS_READ               = 3'b100,
        PZCOREBUS_WRITE_NON_POSTED   = 3'b101,
        PZCOREBUS_ATOMIC             = 3'b110,
        PZCOREBUS_MESSAGE_NON_POSTED = 3'b111
    } pzcorebus_command_type;

    typedef enum logic [1:0] {
        PZCOREBUS_NULL_RESPONSE      = 2'b00,
        PZCOREBUS_RESPONSE           = 2'b01,
        PZCOREBUS_RESPONSE_WITH_DATA = 2'b10
    } pzcorebus_response_type;

    function automatic logic is_posted_command(input pzcorebus_command_type cmd);
        return !cmd[2];
    endfunction

endpackage

// File: rtl/pzcorebus_response_filter_pkg.sv
// Shared types for the response filter: per-entry state and ID-to-index mapping.
package pzcorebus_response_filter_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } entry_state_e;

    // IDs wider than 32 bits are not supported by this helper.
    function automatic int unsigned entry_index(
        input logic [31:0]  id,
        input int unsigned  index_width
    );
        return int'(id & ((32'd1 << index_width) - 32'd1));
    endfunction

endpackage

// File: rtl/pzcorebus_response_filter_entry.sv
// One tracked ID: IDLE/PENDING state flop plus, with
// PZCOREBUS_RESPONSE_FILTER_DRAIN_EN, a watchdog that abandons a stale entry.
module pzcorebus_response_filter_entry
    import pzcorebus_response_filter_pkg::*;
#(
    parameter int DRAIN_CYCLES = 1024
)(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_set,
    input  logic i_clear,
    output logic o_pending,
    output logic o_drain_fire
);

    if (DRAIN_CYCLES < 2) begin : g_bad_drain_cycles
        $error("DRAIN_CYCLES must be at least 2");
    end

    entry_state_e r_state;

    assign o_pending = (r_state == PENDING);

`ifdef PZCOREBUS_RESPONSE_FILTER_DRAIN_EN
    localparam int CNT_WIDTH = $clog2(DRAIN_CYCLES);

    logic [CNT_WIDTH-1:0] r_count;

    assign o_drain_fire = o_pending && (r_count == CNT_WIDTH'(DRAIN_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_set) begin
            r_count <= '0;
        end else if (o_pending) begin
            r_count <= r_count + CNT_WIDTH'(1);
        end
    end
`else
    assign o_drain_fire = 1'b0;
`endif

    // Set and clear are mutually exclusive: set needs IDLE, clear/fire need PENDING.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else if (i_set) begin
            r_state <= PENDING;
        end else if (i_clear || o_drain_fire) begin
            r_state <= IDLE;
        end
    end

endmodule

// File: rtl/pzcorebus_response_filter.sv
// CSR-profile response filter: stalls reissue of pending IDs and drops stray
// responses. Optional watchdog: PZCOREBUS_RESPONSE_FILTER_DRAIN_EN.
module pzcorebus_response_filter
    import pzcorebus_pkg::*, pzcorebus_response_filter_pkg::*;
#(
    parameter int ENTRIES           = 4,
    parameter int ID_WIDTH          = 8,
    parameter int ADDR_WIDTH        = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int STRAY_COUNT_WIDTH = 16,
    parameter int DRAIN_CYCLES      = 1024
)(
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [ID_WIDTH-1:0]                   i_base_id,
    input  logic                                  i_mcmd_valid,
    output logic                                  o_scmd_accept,
    input  logic [$bits(pzcorebus_command_type)-1:0]  i_mcmd,
    input  logic [ID_WIDTH-1:0]                   i_mid,
    input  logic [ADDR_WIDTH-1:0]                 i_maddr,
    input  logic [DATA_WIDTH-1:0]                 i_mdata,
    output logic                                  o_mcmd_valid,
    input  logic                                  i_scmd_accept,
    output logic [$bits(pzcorebus_command_type)-1:0]  o_mcmd,
    output logic [ID_WIDTH-1:0]                   o_mid,
    output logic [ADDR_WIDTH-1:0]                 o_maddr,
    output logic [DATA_WIDTH-1:0]                 o_mdata,
    input  logic                                  i_sresp_valid,
    output logic                                  o_mresp_accept,
    input  logic [$bits(pzcorebus_response_type)-1:0] i_sresp,
    input  logic [ID_WIDTH-1:0]                   i_sid,
    input  logic                                  i_serror,
    input  logic [DATA_WIDTH-1:0]                 i_sdata,
    output logic                                  o_sresp_valid,
    input  logic                                  i_mresp_accept,
    output logic [$bits(pzcorebus_response_type)-1:0] o_sresp,
    output logic [ID_WIDTH-1:0]                   o_sid,
    output logic                                  o_serror,
    output logic [DATA_WIDTH-1:0]                 o_sdata,
    output logic [$clog2(ENTRIES):0]              o_outstanding,
    output logic [STRAY_COUNT_WIDTH-1:0]          o_stray_count,
`ifdef PZCOREBUS_RESPONSE_FILTER_DRAIN_EN
    output logic                                  o_drain_timeout,
`endif
    output logic                                  o_stray
);

    localparam int INDEX_WIDTH = $clog2(ENTRIES);
    localparam int CW          = INDEX_WIDTH + 1;

    if ((ENTRIES < 2) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
        $error("ENTRIES must be a power of two of at least 2");
    end

    logic [ENTRIES-1:0]     w_pending;
    logic [ENTRIES-1:0]     w_drain_fire;
    logic [ENTRIES-1:0]     w_set;
    logic [ENTRIES-1:0]     w_clear;
    logic [ENTRIES-1:0]     w_forced;
    logic [CW-1:0]          w_forced_count;
    logic [INDEX_WIDTH-1:0] w_cmd_index;
    logic [INDEX_WIDTH-1:0] w_resp_index;
    logic                   w_cmd_posted;
    logic                   w_cmd_blocked;
    logic                   w_cmd_ack_np;
    logic                   w_base_match;
    logic                   w_owned;
    logic                   w_resp_ack_owned;
    logic                   w_stray_drop;
    logic                   w_unused;

    logic [CW-1:0]                r_outstanding;
    logic [STRAY_COUNT_WIDTH-1:0] r_stray_count;
    logic                         r_stray;

    assign w_unused = &{1'b0, i_base_id[INDEX_WIDTH-1:0]};

    // Command path
    assign w_cmd_index   = INDEX_WIDTH'(entry_index(32'(i_mid), INDEX_WIDTH));
    assign w_cmd_posted  = is_posted_command(pzcorebus_command_type'(i_mcmd));
    assign w_cmd_blocked = !w_cmd_posted && w_pending[w_cmd_index];
    assign o_mcmd_valid  = i_mcmd_valid && !w_cmd_blocked;
    assign o_scmd_accept = i_scmd_accept && !w_cmd_blocked;
    assign w_cmd_ack_np  = o_mcmd_valid && i_scmd_accept && !w_cmd_posted;
    assign o_mcmd        = i_mcmd;
    assign o_mid         = i_mid;
    assign o_maddr       = i_maddr;
    assign o_mdata       = i_mdata;

    // Response path
    assign w_resp_index     = INDEX_WIDTH'(entry_index(32'(i_sid), INDEX_WIDTH));
    assign w_base_match     = (i_sid[ID_WIDTH-1:INDEX_WIDTH] == i_base_id[ID_WIDTH-1:INDEX_WIDTH]);
    assign w_owned          = w_base_match && w_pending[w_resp_index];
    assign o_sresp_valid    = i_sresp_valid && w_owned;
    assign o_mresp_accept   = w_owned ? i_mresp_accept : 1'b1;
    assign w_resp_ack_owned = i_sresp_valid && w_owned && i_mresp_accept;
    assign w_stray_drop     = i_sresp_valid && !w_owned;
    assign o_sresp          = i_sresp;
    assign o_sid            = i_sid;
    assign o_serror         = i_serror;
    assign o_sdata          = i_sdata;

    always_comb begin
        w_set          = '0;
        w_clear        = '0;
        w_forced_count = '0;
        for (int unsigned k = 0; k < ENTRIES; k++) begin
            w_set[k]   = w_cmd_ack_np && (w_cmd_index == INDEX_WIDTH'(k));
            w_clear[k] = w_resp_ack_owned && (w_resp_index == INDEX_WIDTH'(k));
        end
        // An owned ack wins over a watchdog force on the same edge.
        w_forced = w_drain_fire & ~w_clear;
        for (int unsigned k = 0; k < ENTRIES; k++) begin
            w_forced_count = w_forced_count + CW'(w_forced[k]);
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
        pzcorebus_response_filter_entry #(
            .DRAIN_CYCLES (DRAIN_CYCLES)
        ) u_entry (
            .i_clk        (i_clk),
            .i_rst        (i_rst),
            .i_set        (w_set[g]),
            .i_clear      (w_clear[g]),
            .o_pending    (w_pending[g]),
            .o_drain_fire (w_drain_fire[g])
        );
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_outstanding <= '0;
            r_stray_count <= '0;
            r_stray       <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_cmd_ack_np)
                           - CW'(w_resp_ack_owned) - w_forced_count;
            r_stray       <= w_stray_drop;
            if (w_stray_drop && (r_stray_count != '1)) begin
                r_stray_count <= r_stray_count + STRAY_COUNT_WIDTH'(1);
            end
        end
    end

`ifdef PZCOREBUS_RESPONSE_FILTER_DRAIN_EN
    logic r_drain_timeout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_drain_timeout <= 1'b0;
        end else begin
            r_drain_timeout <= |w_forced;
        end
    end

    assign o_drain_timeout = r_drain_timeout;
`endif

    assign o_outstanding = r_outstanding;
    assign o_stray_count = r_stray_count;
    assign o_stray       = r_stray;

endmodule

// File: tb/tb_pzcorebus_response_filter.sv
// Directed bench for pzcorebus_response_filter; covers the drain watchdog
// when built with PZCOREBUS_RESPONSE_FILTER_DRAIN_EN.
module tb_pzcorebus_response_filter;
    import pzcorebus_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_base_id;
    logic        i_mcmd_valid;
    logic        o_scmd_accept;
    logic [2:0]  i_mcmd;
    logic [7:0]  i_mid;
    logic [15:0] i_maddr;
    logic [31:0] i_mdata;
    logic        o_mcmd_valid;
    logic        i_scmd_accept;
    logic [2:0]  o_mcmd;
    logic [7:0]  o_mid;
    logic [15:0] o_maddr;
    logic [31:0] o_mdata;
    logic        i_sresp_valid;
    logic        o_mresp_accept;
    logic [1:0]  i_sresp;
    logic [7:0]  i_sid;
    logic        i_serror;
    logic [31:0] i_sdata;
    logic        o_sresp_valid;
    logic        i_mresp_accept;
    logic [1:0]  o_sresp;
    logic [7:0]  o_sid;
    logic        o_serror;
    logic [31:0] o_sdata;
    logic [2:0]  o_outstanding;
    logic [15:0] o_stray_count;
    logic        o_stray;
`ifdef PZCOREBUS_RESPONSE_FILTER_DRAIN_EN
    logic        o_drain_timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    pzcorebus_response_filter #(
        .ENTRIES           (4),
        .ID_WIDTH          (8),
        .ADDR_WIDTH        (16),
        .DATA_WIDTH        (32),
        .STRAY_COUNT_WIDTH (16),
        .DRAIN_CYCLES      (8)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_base_id      (i_base_id),
        .i_mcmd_valid   (i_mcmd_valid),
        .o_scmd_accept  (o_scmd_accept),
        .i_mcmd         (i_mcmd),
        .i_mid          (i_mid),
        .i_maddr        (i_maddr),
        .i_mdata        (i_mdata),
        .o_mcmd_valid   (o_mcmd_valid),
        .i_scmd_accept  (i_scmd_accept),
        .o_mcmd         (o_mcmd),
        .o_mid          (o_mid),
        .o_maddr        (o_maddr),
        .o_mdata        (o_mdata),
        .i_sresp_valid  (i_sresp_valid),
        .o_mresp_accept (o_mresp_accept),
        .i_sresp        (i_sresp),
        .i_sid          (i_sid),
        .i_serror       (i_serror),
        .i_sdata        (i_sdata),
        .o_sresp_valid  (o_sresp_valid),
        .i_mresp_accept (i_mresp_accept),
        .o_sresp        (o_sresp),
        .o_sid          (o_sid),
        .o_serror       (o_serror),
        .o_sdata        (o_sdata),
        .o_outstanding  (o_outstanding),
        .o_stray_count  (o_stray_count),
`ifdef PZCOREBUS_RESPONSE_FILTER_DRAIN_EN
        .o_drain_timeout(o_drain_timeout),
`endif
        .o_stray        (o_stray)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic cmd(input logic v, input pzcorebus_command_type c, input logic [7:0] id);
        i_mcmd_valid = v;
        i_mcmd       = c;
        i_mid        = id;
        i_maddr      = {8'h10, id};
        i_mdata      = {24'hABCDEF, id};
    endtask

    task automatic resp(input logic v, input logic [7:0] id, input logic err);
        i_sresp_valid = v;
        i_sid         = id;
        i_serror      = err;
        i_sdata       = {24'h5A5A5A, id};
    endtask

    initial begin
        i_rst          = 1'b1;
        i_base_id      = 8'h40;
        i_scmd_accept  = 1'b1;
        i_mresp_accept = 1'b1;
        i_sresp        = PZCOREBUS_RESPONSE_WITH_DATA;
        cmd(1'b0, PZCOREBUS_READ, 8'h00);
        resp(1'b0, 8'h00, 1'b0);
        repeat (2) tick();
        i_rst = 1'b0;
        tick();

        check("rst_outstanding", 32'(o_outstanding), 32'd0);
        check("rst_stray_count", 32'(o_stray_count), 32'd0);
        check("rst_stray",       32'(o_stray),       32'd0);
`ifdef PZCOREBUS_RESPONSE_FILTER_DRAIN_EN
        check("rst_drain_timeout", 32'(o_drain_timeout), 32'd0);
`endif

        // Basic READ 0x40 round trip
        cmd(1'b1, PZCOREBUS_READ, 8'h40);
        #1;
        check("rd40_mcmd_valid", 32'(o_mcmd_valid),  32'd1);
        check("rd40_accept",     32'(o_scmd_accept), 32'd1);
        check("rd40_mid",        32'(o_mid),         32'h40);
        check("rd40_maddr",      32'(o_maddr),       32'h1040);
        tick();
        cmd(1'b0, PZCOREBUS_READ, 8'h40);
        check("rd40_outstanding", 32'(o_outstanding), 32'd1);
        resp(1'b1, 8'h40, 1'b0);
        #1;
        check("rsp40_valid",  32'(o_sresp_valid),  32'd1);
        check("rsp40_accept", 32'(o_mresp_accept), 32'd1);
        check("rsp40_sdata",  o_sdata,             32'h5A5A5A40);
        tick();
        resp(1'b0, 8'h40, 1'b0);
        check("rsp40_outstanding", 32'(o_outstanding), 32'd0);
        check("rsp40_no_stray",    32'(o_stray),       32'd0);

        // Reissue of 0x41 stalls until its response is acked
        cmd(1'b1, PZCOREBUS_READ, 8'h41);
        tick();
        check("rd41_outstanding", 32'(o_outstanding), 32'd1);
        #1;
        check("rd41_again_accept", 32'(o_scmd_accept), 32'd0);
        check("rd41_again_valid",  32'(o_mcmd_valid),  32'd0);
        tick();
        check("rd41_stall_outstanding", 32'(o_outstanding), 32'd1);
        resp(1'b1, 8'h41, 1'b0);
        #1;
        check("rd41_stall_same_cycle", 32'(o_scmd_accept), 32'd0);
        check("rsp41_valid",           32'(o_sresp_valid), 32'd1);
        tick();
        resp(1'b0, 8'h41, 1'b0);
        check("rsp41_outstanding", 32'(o_outstanding), 32'd0);
        #1;
        check("rd41_released_accept", 32'(o_scmd_accept), 32'd1);
        check("rd41_released_valid",  32'(o_mcmd_valid),  32'd1);
        tick();
        cmd(1'b0, PZCOREBUS_READ, 8'h41);
        check("rd41_second_outstanding", 32'(o_outstanding), 32'd1);
        // Upstream back-pressure holds the response and the entry
        resp(1'b1, 8'h41, 1'b0);
        i_mresp_accept = 1'b0;
        #1;
        check("rsp41_bp_valid",  32'(o_sresp_valid),  32'd1);
        check("rsp41_bp_accept", 32'(o_mresp_accept), 32'd0);
        tick();
        check("rsp41_bp_outstanding", 32'(o_outstanding), 32'd1);
        i_mresp_accept = 1'b1;
        tick();
        resp(1'b0, 8'h41, 1'b0);
        check("rsp41_second_outstanding", 32'(o_outstanding), 32'd0);
        check("rsp41_bp_no_stray",        32'(o_stray_count), 32'd0);

        // Stray on IDLE entry 2 is dropped even with upstream not accepting
        resp(1'b1, 8'h42, 1'b0);
        i_mresp_accept = 1'b0;
        #1;
        check("stray42_valid",  32'(o_sresp_valid),  32'd0);
        check("stray42_accept", 32'(o_mresp_accept), 32'd1);
        tick();
        resp(1'b0, 8'h42, 1'b0);
        i_mresp_accept = 1'b1;
        check("stray42_pulse", 32'(o_stray),       32'd1);
        check("stray42_count", 32'(o_stray_count), 32'd1);
        tick();
        check("stray42_pulse_end", 32'(o_stray), 32'd0);

        // Foreign base: sid 0x00 maps to pending entry 0 but is not owned
        cmd(1'b1, PZCOREBUS_READ, 8'h40);
        tick();
        cmd(1'b0, PZCOREBUS_READ, 8'h40);
        resp(1'b1, 8'h00, 1'b0);
        #1;
        check("foreign_valid", 32'(o_sresp_valid), 32'd0);
        tick();
        check("foreign_count",       32'(o_stray_count), 32'd2);
        check("foreign_outstanding", 32'(o_outstanding), 32'd1);
        resp(1'b1, 8'h40, 1'b0);
        tick();
        resp(1'b0, 8'h40, 1'b0);
        check("foreign_cleanup", 32'(o_outstanding), 32'd0);

        // Posted WRITE to pending ID 0x43 passes without touching state
        cmd(1'b1, PZCOREBUS_READ, 8'h43);
        tick();
        cmd(1'b1, PZCOREBUS_WRITE, 8'h43);
        #1;
        check("wr43_valid",  32'(o_mcmd_valid),  32'd1);
        check("wr43_accept", 32'(o_scmd_accept), 32'd1);
        check("wr43_mcmd",   32'(o_mcmd),        32'(PZCOREBUS_WRITE));
        tick();
        cmd(1'b1, PZCOREBUS_READ, 8'h43);
        check("wr43_outstanding", 32'(o_outstanding), 32'd1);
        #1;
        check("rd43_still_blocked", 32'(o_scmd_accept), 32'd0);
        cmd(1'b0, PZCOREBUS_READ, 8'h43);
        resp(1'b1, 8'h43, 1'b1);
        #1;
        check("rsp43_err_valid", 32'(o_sresp_valid), 32'd1);
        check("rsp43_serror",    32'(o_serror),      32'd1);
        tick();
        resp(1'b0, 8'h43, 1'b0);
        check("rsp43_outstanding", 32'(o_outstanding), 32'd0);

        // Same cycle: command ack 0x40 and stray 0x40 on the IDLE entry
        cmd(1'b1, PZCOREBUS_READ, 8'h40);
        resp(1'b1, 8'h40, 1'b0);
        #1;
        check("same_cmd_valid",  32'(o_mcmd_valid),   32'd1);
        check("same_resp_valid", 32'(o_sresp_valid),  32'd0);
        check("same_resp_accept",32'(o_mresp_accept), 32'd1);
        tick();
        cmd(1'b0, PZCOREBUS_READ, 8'h40);
        resp(1'b0, 8'h40, 1'b0);
        check("same_outstanding", 32'(o_outstanding), 32'd1);
        check("same_stray_count", 32'(o_stray_count), 32'd3);
        check("same_stray_pulse", 32'(o_stray),       32'd1);
        resp(1'b1, 8'h40, 1'b0);
        #1;
        check("same_entry_pending", 32'(o_sresp_valid), 32'd1);
        tick();
        resp(1'b0, 8'h40, 1'b0);
        check("same_cleanup", 32'(o_outstanding), 32'd0);

        // Saturation: drive strays until all-ones, then one more
        resp(1'b1, 8'h42, 1'b0);
        repeat (16'hFFFF - 3) tick();
        check("sat_reach", 32'(o_stray_count), 32'hFFFF);
        tick();
        resp(1'b0, 8'h42, 1'b0);
        check("sat_hold", 32'(o_stray_count), 32'hFFFF);
        check("sat_pulse", 32'(o_stray), 32'd1);

        // Async reset mid-transaction discards the pending entry
        cmd(1'b1, PZCOREBUS_READ, 8'h41);
        tick();
        cmd(1'b0, PZCOREBUS_READ, 8'h41);
        check("pre_rst_outstanding", 32'(o_outstanding), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check("async_rst_outstanding", 32'(o_outstanding), 32'd0);
        check("async_rst_stray_count", 32'(o_stray_count), 32'd0);
        i_rst = 1'b0;
        tick();
        resp(1'b1, 8'h41, 1'b0);
        #1;
        check("post_rst_stray_valid", 32'(o_sresp_valid), 32'd0);
        tick();
        resp(1'b0, 8'h41, 1'b0);
        check("post_rst_stray_count", 32'(o_stray_count), 32'd1);

`ifdef PZCOREBUS_RESPONSE_FILTER_DRAIN_EN
        // Watchdog: READ 0x40 with no response, pulse 8 cycles after the ack
        cmd(1'b1, PZCOREBUS_READ, 8'h40);
        tick();
        cmd(1'b0, PZCOREBUS_READ, 8'h40);
        for (int c = 1; c < 8; c++) begin
            check("drain_quiet", 32'(o_drain_timeout), 32'd0);
            tick();
        end
        check("drain_quiet_last", 32'(o_drain_timeout), 32'd0);
        tick();
        check("drain_pulse",       32'(o_drain_timeout), 32'd1);
        check("drain_outstanding", 32'(o_outstanding),   32'd0);
        resp(1'b1, 8'h40, 1'b0);
        #1;
        check("drain_late_valid", 32'(o_sresp_valid), 32'd0);
        tick();
        resp(1'b0, 8'h40, 1'b0);
        check("drain_pulse_end",  32'(o_drain_timeout), 32'd0);
        check("drain_late_stray", 32'(o_stray_count),   32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
